recombinador: RTL and testbench

Reverse path of the recirculator. Each of the four 8-bit lanes has two sources: words returned on the recirculated (deactivated) path and fresh words from the upstream source. The block merges both sources into one registered valid/data stream per lane, so nothing is lost while the recirculator is inactive. Recirculated words always win arbitration. Fresh words that lose arbitration wait in a per-lane FIFO, and a `pause` output throttles the source before those FIFOs overflow.

---
 rtl/recombinador_pkg.sv | 33 +++
 rtl/fifo_recombinador.sv | 72 +++++++
 rtl/recombinador.sv | 137 +++++++++++++
 tb/tb_recombinador.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/recombinador_pkg.sv
// Shared constants, lane arbitration type and helper for the recombinador.
// Default DEPTH/PAUSE_TH macros are shared with the recirculator and its bench.
`ifndef RECOMB_DEFS_SV
`define RECOMB_DEFS_SV
`define RECOMB_DEPTH    4
`define RECOMB_PAUSE_TH 3
`endif

package recombinador_pkg;

    localparam int NUM_LANES    = 4;
    localparam int DATA_W       = 8;
    localparam int DEF_DEPTH    = `RECOMB_DEPTH;
    localparam int DEF_PAUSE_TH = `RECOMB_PAUSE_TH;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_REC,
        SRC_FIFO,
        SRC_BYPASS
    } lane_src_e;

    // Recirculated words always win; queued fresh words beat new ones.
    function automatic lane_src_e arbitrate(input logic rec,
                                            input logic queued,
                                            input logic fresh);
        if (rec)         return SRC_REC;
        else if (queued) return SRC_FIFO;
        else if (fresh)  return SRC_BYPASS;
        else             return SRC_NONE;
    endfunction

endpackage

// File: rtl/fifo_recombinador.sv
// Per-lane FIFO holding fresh words that lost arbitration.
// A push while full is accepted only if a pop frees a slot on the same edge.
module fifo_recombinador
    import recombinador_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wrap_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/recombinador.sv
// Merges recirculated and fresh words into one registered stream per lane,
// queueing fresh words that lose arbitration and throttling the source.
module recombinador
    import recombinador_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PAUSE_TH = DEF_PAUSE_TH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_rec0,
    input  logic              valid_rec1,
    input  logic              valid_rec2,
    input  logic              valid_rec3,
    input  logic [DATA_W-1:0] data_rec0,
    input  logic [DATA_W-1:0] data_rec1,
    input  logic [DATA_W-1:0] data_rec2,
    input  logic [DATA_W-1:0] data_rec3,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              valid2,
    input  logic              valid3,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              valid_out2,
    output logic              valid_out3,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              pause,
    output logic [NUM_LANES-1:0] overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_LANES-1:0] vrec, vin, push, pop, full, empty;
    logic [DATA_W-1:0]    drec [NUM_LANES];
    logic [DATA_W-1:0]    din  [NUM_LANES];
    logic [DATA_W-1:0]    head [NUM_LANES];
    logic [CNT_W-1:0]     cnt  [NUM_LANES];

    logic [NUM_LANES-1:0] valid_out_q, valid_out_d;
    logic [DATA_W-1:0]    data_out_q [NUM_LANES];
    logic [DATA_W-1:0]    data_out_d [NUM_LANES];
    logic [NUM_LANES-1:0] overflow_q, overflow_d;
    lane_src_e            src [NUM_LANES];

    assign vrec = {valid_rec3, valid_rec2, valid_rec1, valid_rec0};
    assign vin  = {valid3, valid2, valid1, valid0};
    assign drec[0] = data_rec0;
    assign drec[1] = data_rec1;
    assign drec[2] = data_rec2;
    assign drec[3] = data_rec3;
    assign din[0]  = data_in0;
    assign din[1]  = data_in1;
    assign din[2]  = data_in2;
    assign din[3]  = data_in3;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fifo_recombinador #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din[g]),
            .head  (head[g]),
            .count (cnt[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    always_comb begin
        valid_out_d = '0;
        push        = '0;
        pop         = '0;
        overflow_d  = overflow_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            data_out_d[i] = '0;
            src[i] = arbitrate(vrec[i], !empty[i], vin[i]);
            unique case (src[i])
                SRC_REC: begin
                    valid_out_d[i] = 1'b1;
                    data_out_d[i]  = drec[i];
                    push[i]        = vin[i] && !full[i];
                    if (vin[i] && full[i]) overflow_d[i] = 1'b1;
                end
                SRC_FIFO: begin
                    valid_out_d[i] = 1'b1;
                    data_out_d[i]  = head[i];
                    pop[i]         = 1'b1;
                    push[i]        = vin[i];
                end
                SRC_BYPASS: begin
                    valid_out_d[i] = 1'b1;
                    data_out_d[i]  = din[i];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pause = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cnt[i] >= CNT_W'(PAUSE_TH)) pause = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= '0;
            data_out_q  <= '{default: '0};
            overflow_q  <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign valid_out0 = valid_out_q[0];
    assign valid_out1 = valid_out_q[1];
    assign valid_out2 = valid_out_q[2];
    assign valid_out3 = valid_out_q[3];
    assign data_out0  = data_out_q[0];
    assign data_out1  = data_out_q[1];
    assign data_out2  = data_out_q[2];
    assign data_out3  = data_out_q[3];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_recombinador.sv
// Directed bench for recombinador: reset, bypass, priority/order,
// pause/overflow, full push+pop and mid-operation reset.
module tb_recombinador;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_rec0, valid_rec1, valid_rec2, valid_rec3;
    logic [7:0] data_rec0, data_rec1, data_rec2, data_rec3;
    logic       valid0, valid1, valid2, valid3;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       pause;
    logic [3:0] overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    recombinador #(.DEPTH(4), .PAUSE_TH(3)) dut (
        .clk(clk), .reset(reset),
        .valid_rec0(valid_rec0), .valid_rec1(valid_rec1),
        .valid_rec2(valid_rec2), .valid_rec3(valid_rec3),
        .data_rec0(data_rec0), .data_rec1(data_rec1),
        .data_rec2(data_rec2), .data_rec3(data_rec3),
        .valid0(valid0), .valid1(valid1),
        .valid2(valid2), .valid3(valid3),
        .data_in0(data_in0), .data_in1(data_in1),
        .data_in2(data_in2), .data_in3(data_in3),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .valid_out2(valid_out2), .valid_out3(valid_out3),
        .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3),
        .pause(pause), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {valid_rec0, valid_rec1, valid_rec2, valid_rec3} = '0;
        {valid0, valid1, valid2, valid3} = '0;
        {data_rec0, data_rec1, data_rec2, data_rec3} = '0;
        {data_in0, data_in1, data_in2, data_in3} = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;

        // 1. reset held 2 cycles while inputs toggle
        for (int c = 0; c < 2; c++) begin
            {valid_rec0, valid_rec1, valid_rec2, valid_rec3} = 4'hF;
            {valid0, valid1, valid2, valid3} = 4'hF;
            data_rec0 = 8'hDE; data_in1 = 8'hAD; data_in2 = 8'hBE;
            data_rec3 = 8'hEF;
            step();
            clear_inputs();
        end
        check("rst_vout", {valid_out3, valid_out2, valid_out1, valid_out0}, 0);
        check("rst_dout", {data_out3, data_out2, data_out1, data_out0}, 0);
        check("rst_pause", pause, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        step();

        // 2. bypass on lane 0
        valid0 = 1'b1; data_in0 = 8'hA5;
        step();
        clear_inputs();
        check("byp_v", valid_out0, 1);
        check("byp_d", data_out0, 8'hA5);
        check("byp_cnt", dut.g_lane[0].u_fifo.count, 0);
        step();
        check("byp_v_idle", valid_out0, 0);
        check("byp_d_idle", data_out0, 0);

        // 3. priority and order on lane 1
        valid_rec1 = 1'b1; data_rec1 = 8'h11;
        valid1 = 1'b1; data_in1 = 8'h22;
        step();
        check("ord_v1", valid_out1, 1);
        check("ord_d1", data_out1, 8'h11);
        clear_inputs();
        valid1 = 1'b1; data_in1 = 8'h33;
        step();
        clear_inputs();
        check("ord_d2", data_out1, 8'h22);
        step();
        check("ord_d3", data_out1, 8'h33);
        step();
        check("ord_v4", valid_out1, 0);
        check("ord_d4", data_out1, 0);

        // 4. pause and overflow on lane 2
        for (int k = 1; k <= 6; k++) begin
            valid_rec2 = 1'b1; data_rec2 = 8'(8'h80 + k);
            valid2 = 1'b1; data_in2 = 8'(k);
            step();
            check("po_rec", data_out2, 8'(8'h80 + k));
            check("po_cnt", dut.g_lane[2].u_fifo.count, (k < 4) ? k : 4);
            check("po_pause", pause, (k >= 3) ? 1 : 0);
            check("po_ovf", overflow[2], (k >= 5) ? 1 : 0);
        end
        clear_inputs();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("po_drain_v", valid_out2, 1);
            check("po_drain_d", data_out2, 8'(k));
            check("po_drain_pause", pause, (4 - k >= 3) ? 1 : 0);
        end
        step();
        check("po_end_v", valid_out2, 0);
        check("po_end_ovf", overflow, 4'b0100);

        // 5. full lane 3 with simultaneous push/pop
        for (int k = 1; k <= 4; k++) begin
            valid_rec3 = 1'b1; data_rec3 = 8'h90;
            valid3 = 1'b1; data_in3 = 8'(8'h30 + k);
            step();
        end
        clear_inputs();
        check("fp_cnt_full", dut.g_lane[3].u_fifo.count, 4);
        check("fp_ovf_full", overflow[3], 0);
        valid3 = 1'b1; data_in3 = 8'h40;
        step();
        clear_inputs();
        check("fp_head", data_out3, 8'h31);
        check("fp_cnt", dut.g_lane[3].u_fifo.count, 4);
        check("fp_ovf", overflow[3], 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("fp_drain", data_out3, (k < 3) ? 8'(8'h32 + k) : 8'h40);
        end
        step();
        check("fp_end_v", valid_out3, 0);

        // 6. mid-operation reset with 2 words queued on lane 3
        for (int k = 1; k <= 2; k++) begin
            valid_rec3 = 1'b1; data_rec3 = 8'h70;
            valid3 = 1'b1; data_in3 = 8'(8'h60 + k);
            step();
        end
        clear_inputs();
        check("mr_cnt_pre", dut.g_lane[3].u_fifo.count, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_cnt", dut.g_lane[3].u_fifo.count, 0);
        check("mr_ovf", overflow, 0);
        check("mr_pause", pause, 0);
        check("mr_v", valid_out3, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("mr_no_stale_v", valid_out3, 0);
            check("mr_no_stale_d", data_out3, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
